// File: rtl/lgn_pixel_loader.sv
// Pad-side frame loader: synchronises an asynchronous pixel strobe, assembles a
// binarised image from packed or thresholded grayscale writes, and hands it off via valid/ack.
module lgn_pixel_loader #(
    parameter int BUS_WIDTH = 8,
    parameter int PIXELS    = 784,
    localparam int CW       = $clog2(PIXELS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_strobe,
    input  logic [BUS_WIDTH-1:0] data_in,
    input  logic                 mode,
    input  logic [BUS_WIDTH-1:0] threshold,
    input  logic                 frame_ack,
    output logic [PIXELS-1:0]    frame_bits,
    output logic                 frame_valid,
    output logic [CW-1:0]        pixel_count,
    output logic                 overrun
);

    localparam int WW = PIXELS + BUS_WIDTH;

    logic                 s1, s2, s3;
    logic                 wr_evt;
    logic                 mode_q;
    logic [BUS_WIDTH-1:0] thr_q;

    // Sync flops reset high so a strobe already high at reset release is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= wr_strobe;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign wr_evt = s2 & ~s3;

    logic                 first_write;
    logic                 eff_mode;
    logic [BUS_WIDTH-1:0] eff_thr;
    logic                 gray_pix;
    logic [BUS_WIDTH-1:0] lane_mask;
    logic [BUS_WIDTH-1:0] lane_data;
    logic [WW-1:0]        wide_mask;
    logic [WW-1:0]        wide_data;
    logic [PIXELS-1:0]    frame_next;
    logic [CW-1:0]        remaining;
    logic [CW-1:0]        step;
    logic [CW-1:0]        count_sum;
    logic                 frame_done;
    logic                 accept;

    // The first write of a frame uses the live mode/threshold, which are latched on that write.
    assign first_write = (pixel_count == '0);
    assign eff_mode    = first_write ? mode : mode_q;
    assign eff_thr     = first_write ? threshold : thr_q;
    assign gray_pix    = (data_in >= eff_thr);

    always_comb begin
        lane_mask = '1;
        lane_data = data_in;
        if (eff_mode) begin
            lane_mask = {{(BUS_WIDTH-1){1'b0}}, 1'b1};
            lane_data = {{(BUS_WIDTH-1){1'b0}}, gray_pix};
        end
    end

    // Shifting into a vector wider than the frame drops excess bits of the final packed write.
    assign wide_mask  = {{PIXELS{1'b0}}, lane_mask} << pixel_count;
    assign wide_data  = {{PIXELS{1'b0}}, lane_data} << pixel_count;
    assign frame_next = (frame_bits & ~wide_mask[PIXELS-1:0])
                      | (wide_data[PIXELS-1:0] & wide_mask[PIXELS-1:0]);

    always_comb begin
        remaining = CW'(PIXELS) - pixel_count;
        step      = CW'(1);
        if (!eff_mode)
            step = (remaining < CW'(BUS_WIDTH)) ? remaining : CW'(BUS_WIDTH);
    end

    assign count_sum  = pixel_count + step;
    assign frame_done = (count_sum == CW'(PIXELS));
    assign accept     = wr_evt & (~frame_valid | frame_ack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_bits  <= '0;
            frame_valid <= 1'b0;
            pixel_count <= '0;
            overrun     <= 1'b0;
            mode_q      <= 1'b0;
            thr_q       <= '0;
        end else begin
            if (frame_valid && frame_ack)
                frame_valid <= 1'b0;
            if (wr_evt && frame_valid && !frame_ack)
                overrun <= 1'b1;
            if (accept) begin
                frame_bits <= frame_next;
                if (first_write) begin
                    mode_q <= mode;
                    thr_q  <= threshold;
                end
                if (frame_done) begin
                    pixel_count <= '0;
                    frame_valid <= 1'b1;
                end else begin
                    pixel_count <= count_sum;
                end
            end
        end
    end

endmodule

// File: doc/lgn_pixel_loader.md
# lgn_pixel_loader

Parametrised pad-side frame loader for the logic-gate-network classifier. It turns a slow, asynchronous pixel strobe plus a byte-wide pad bus into a complete binarised image vector. Two input modes are supported: packed 1-bit pixels, or grayscale bytes thresholded on chip. A completed frame is handed to the LGN core through a valid/ack handshake with overrun detection. It sits between the input pads in `chip_core` and the `lgn` instance and replaces direct pad-to-core wiring.

## Interface
Parameters:
- `BUS_WIDTH`, 8: pad data bus width in bits (≥2).
- `PIXELS`, 784: pixels per frame (28×28); width of `frame_bits`.
- `CW`, `$clog2(PIXELS+1)`: width of `pixel_count` (localparam).

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_strobe`  in  1  pad write strobe, asynchronous to `clk`; each rising edge is one write.
- `data_in`  in  BUS_WIDTH  pad data bus for the write.
- `mode`  in  1  0 = packed (BUS_WIDTH pixels per write), 1 = grayscale (one pixel per write, thresholded).
- `threshold`  in  BUS_WIDTH  grayscale threshold; pixel = (`data_in` ≥ `threshold`), unsigned.
- `frame_ack`  in  1  consumer accepts the current frame.
- `frame_bits`  out  PIXELS  image; bit i = pixel i.
- `frame_valid`  out  1  a complete frame is held on `frame_bits`.
- `pixel_count`  out  CW  pixels written into the frame being filled.
- `overrun`  out  1  sticky error: a write was dropped.

## Operation
- Strobe sync: 3-flop chain s1→s2→s3, all reset to 1. `wr_evt` = s2 & ~s3. A strobe held high through reset release produces no write.
- `mode` and `threshold` are latched when the first write of a frame is accepted (`pixel_count`==0). Changes mid-frame have no effect until the next frame.
- Packed write: bits `data_in[j]` go to `frame_bits[pixel_count+j]` for j = 0..BUS_WIDTH-1, only where the index is < PIXELS. Excess bits of the final write are discarded. `pixel_count` advances by min(BUS_WIDTH, PIXELS−pixel_count).
- Grayscale write: `frame_bits[pixel_count]` = (`data_in` ≥ latched threshold). `pixel_count` advances by 1.
- Frame completion: a write that brings the count to PIXELS sets `frame_valid`=1 and `pixel_count`=0 on the same edge.
- While `frame_valid`=1:
  - `frame_bits` is frozen.
  - Any `wr_evt` is dropped and sets `overrun`=1.
  - `frame_ack`=1 clears `frame_valid` on the next edge.
- Simultaneous `frame_ack` and `wr_evt` while valid: ack wins, the write is accepted as pixel(s) 0.. of the new frame, and `overrun` is unchanged.
- `frame_ack` while `frame_valid`=0 is ignored.
- `overrun` clears only on `rst`.
- Unwritten bits of a partially filled frame keep their previous-frame values.

## Timing
- Reset values:
  - `frame_bits`=0, `frame_valid`=0, `pixel_count`=0, `overrun`=0.
  - Latched mode=0, latched threshold=0.
  - Sync flops = 1.
- Write latency: with `wr_strobe` first sampled high at edge k, `wr_evt` is high between edges k+1 and k+2. The write commits, and `data_in` is sampled, at edge k+2.
- Pad protocol:
  - `wr_strobe` high ≥3 cycles and low ≥3 cycles.
  - `data_in` stable from strobe rise to strobe fall.
  - Maximum rate is one write per 6 cycles.
- `frame_valid` rises on the edge committing the last pixel. `frame_bits` is already complete on that edge.
- Reset asserted mid-frame or mid-handshake returns all state to reset values immediately. The partial frame is lost.

## Test plan
- Reset release with `wr_strobe` held high: no write. `pixel_count`=0 and `overrun`=0 after 10 cycles.
- PIXELS=784, BUS_WIDTH=8, mode 0, 98 writes of 0xA5: `frame_valid` at the 98th commit (k+2). Every byte slot of `frame_bits` = 0xA5 (bit 0 = pixel 0). `pixel_count`=0.
- PIXELS=20, BUS_WIDTH=8, mode 0, writes 0xFF, 0xFF, 0x3F: `frame_valid`=1 after the 3rd write. `frame_bits[19:16]`=0xF and the 2 excess bits are discarded.
- Mode 1, threshold 0x80, bytes 0x7F, 0x80, 0xFF, 0x00: pixels 0,1,1,0 and `pixel_count`=4. Changing `threshold` to 0x00 mid-frame leaves later pixels still compared against 0x80.
- Frame valid, write with no ack: `overrun`=1 and `frame_bits` unchanged. A later write with `frame_ack` coincident with `wr_evt`: `frame_valid`→0, `pixel_count`=8 (mode 0), `overrun` stays 1.
- Assert `rst` after 50 writes: all outputs 0 asynchronously. A full frame after release completes normally.
